// File: rtl/stream_framer.sv
// stream_framer: wraps a 32-bit result stream into packets made of a header,
// up to PKT_LEN payload words and a trailer, between two ap_fifo-style ports.
//
// Handshake: a word crosses the input port in any cycle where in_V_read=1,
// and in_V_read is only raised while in_V_empty_n=1. A word crosses the
// output port in any cycle where out_V_write=1, and out_V_write is only
// raised while out_V_full_n=1. Payload words move straight from input to
// output in the same cycle, so a payload pop and its push always coincide.
//
// Header  = {MAGIC, seq[15:0]}
// Trailer = {payload word count, 16-bit sum of all payload half-words}
module stream_framer #(
    parameter int unsigned PKT_LEN = 64,
    parameter logic [15:0] MAGIC   = 16'hA5C3
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic [31:0] in_V_dout,
    input  logic        in_V_empty_n,
    output logic        in_V_read,
    output logic [31:0] out_V_din,
    input  logic        out_V_full_n,
    output logic        out_V_write,
    input  logic        flush,
    output logic        busy,
    output logic        pkt_done,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_PAY  = 2'd2,
        S_TRL  = 2'd3
    } state_e;

    // Payload count that closes a packet, widened so PKT_LEN=65535 compares cleanly.
    localparam logic [16:0] LAST_CNT = 17'(PKT_LEN);

    state_e      state_q, state_d;
    logic [15:0] seq_q, seq_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] csum_q, csum_d;
    logic        pkt_done_q, pkt_done_d;
    logic        xfer;

    // Next-state, datapath updates and port handshakes for the current state.
    always_comb begin
        state_d     = state_q;
        seq_d       = seq_q;
        cnt_d       = cnt_q;
        csum_d      = csum_q;
        pkt_done_d  = 1'b0;
        in_V_read   = 1'b0;
        out_V_write = 1'b0;
        out_V_din   = 32'd0;
        xfer        = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Only look at the input; the first payload word stays queued.
                if (in_V_empty_n) begin
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                out_V_din   = {MAGIC, seq_q};
                out_V_write = out_V_full_n;
                if (out_V_full_n) begin
                    cnt_d   = 16'd0;
                    csum_d  = 16'd0;
                    state_d = S_PAY;
                end
            end
            S_PAY: begin
                xfer        = in_V_empty_n & out_V_full_n;
                out_V_din   = in_V_dout;
                in_V_read   = xfer;
                out_V_write = xfer;
                if (xfer) begin
                    cnt_d  = cnt_q + 16'd1;
                    csum_d = csum_q + in_V_dout[31:16] + in_V_dout[15:0];
                    if (({1'b0, cnt_q} + 17'd1) == LAST_CNT) begin
                        state_d = S_TRL;
                    end
                end else if (flush && !in_V_empty_n && (cnt_q != 16'd0)) begin
                    // Upstream went idle with a partial packet open: close it.
                    state_d = S_TRL;
                end
            end
            S_TRL: begin
                out_V_din   = {cnt_q, csum_q};
                out_V_write = out_V_full_n;
                if (out_V_full_n) begin
                    seq_d      = seq_q + 16'd1;
                    pkt_done_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q    <= S_IDLE;
            seq_q      <= 16'd0;
            cnt_q      <= 16'd0;
            csum_q     <= 16'd0;
            pkt_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            seq_q      <= seq_d;
            cnt_q      <= cnt_d;
            csum_q     <= csum_d;
            pkt_done_q <= pkt_done_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign pkt_done    = pkt_done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_stream_framer.sv
// Bench for stream_framer: two instances (PKT_LEN=4 and PKT_LEN=2) share one
// stimulus source; only the selected instance sees live input.
module tb_stream_framer;

    logic        clk = 1'b0;
    logic        ap_rst;
    logic [31:0] dout_drv;
    logic        empty_n_drv;
    logic        full_n_drv;
    logic        flush_drv;
    int          sel;

    logic        rd4, wr4, busy4, done4;
    logic [31:0] din4;
    logic [1:0]  st4;
    logic        rd2, wr2, busy2, done2;
    logic [31:0] din2;
    logic [1:0]  st2;

    logic        rd_s, wr_s, busy_s, done_s;
    logic [31:0] din_s;

    int n_err = 0;
    int n_checks = 0;

    logic [31:0] stim_q[$];
    logic [31:0] src_q[$];
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    int          rd_cnt;
    int          done_cnt;
    int          exp_pkts;

    // Clock and instances
    always #5 clk = ~clk;

    stream_framer #(.PKT_LEN(4)) dut4 (
        .ap_clk(clk), .ap_rst(ap_rst),
        .in_V_dout(dout_drv),
        .in_V_empty_n(sel == 0 ? empty_n_drv : 1'b0),
        .in_V_read(rd4), .out_V_din(din4),
        .out_V_full_n(sel == 0 ? full_n_drv : 1'b1),
        .out_V_write(wr4),
        .flush(sel == 0 ? flush_drv : 1'b0),
        .busy(busy4), .pkt_done(done4), .dbg_state_o(st4)
    );

    stream_framer #(.PKT_LEN(2)) dut2 (
        .ap_clk(clk), .ap_rst(ap_rst),
        .in_V_dout(dout_drv),
        .in_V_empty_n(sel == 1 ? empty_n_drv : 1'b0),
        .in_V_read(rd2), .out_V_din(din2),
        .out_V_full_n(sel == 1 ? full_n_drv : 1'b1),
        .out_V_write(wr2),
        .flush(sel == 1 ? flush_drv : 1'b0),
        .busy(busy2), .pkt_done(done2), .dbg_state_o(st2)
    );

    assign rd_s   = (sel == 1) ? rd2   : rd4;
    assign wr_s   = (sel == 1) ? wr2   : wr4;
    assign din_s  = (sel == 1) ? din2  : din4;
    assign busy_s = (sel == 1) ? busy2 : busy4;
    assign done_s = (sel == 1) ? done2 : done4;

    // Reference model: cut the word list into PKT_LEN chunks, the last one
    // possibly short (closed by flush), each wrapped in header and trailer.
    task automatic build_exp(input int plen, input int seq0);
        int n;
        int seq;
        n = stim_q.size();
        seq = seq0;
        exp_q.delete();
        exp_pkts = 0;
        for (int i = 0; i < n; i += plen) begin
            int m;
            int sum;
            m = (n - i < plen) ? (n - i) : plen;
            sum = 0;
            exp_q.push_back({16'hA5C3, 16'(seq % 65536)});
            for (int j = 0; j < m; j++) begin
                sum += int'(stim_q[i + j] >> 16) + int'(stim_q[i + j] & 32'hFFFF);
                exp_q.push_back(stim_q[i + j]);
            end
            exp_q.push_back({16'(m), 16'(sum % 65536)});
            seq++;
            exp_pkts++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        ap_rst = 1'b1;
        empty_n_drv = 1'b0;
        full_n_drv = 1'b1;
        flush_drv = 1'b0;
        dout_drv = 32'd0;
        src_q.delete();
        @(negedge clk);
        ap_rst = 1'b0;
        #1;
    endtask

    // Driver plus protocol monitor for the selected instance.
    task automatic drive_stream(input int max_cycles, input int bp_pct,
                                input int gap_pct, input bit do_flush,
                                input int stop_reads);
        int  idle_run;
        bit  finished;
        bit  have;
        got_q.delete();
        rd_cnt = 0;
        done_cnt = 0;
        idle_run = 0;
        finished = 0;
        for (int c = 0; c < max_cycles && !finished; c++) begin
            @(negedge clk);
            have = (src_q.size() > 0) && ($urandom_range(99) >= gap_pct);
            empty_n_drv = have;
            dout_drv = have ? src_q[0] : $urandom();
            full_n_drv = ($urandom_range(99) >= bp_pct);
            flush_drv = do_flush && (src_q.size() == 0 || have);
            #1;
            n_checks++;
            if (rd_s && !empty_n_drv) begin
                n_err++;
                $display("FAIL read_when_empty: in_V_read=%0b in_V_empty_n=%0b", rd_s, empty_n_drv);
            end
            n_checks++;
            if (wr_s && !full_n_drv) begin
                n_err++;
                $display("FAIL write_when_full: out_V_write=%0b out_V_full_n=%0b", wr_s, full_n_drv);
            end
            if (wr_s) got_q.push_back(din_s);
            if (rd_s) begin
                if (src_q.size() > 0) void'(src_q.pop_front());
                rd_cnt++;
            end
            if (done_s) done_cnt++;
            if (stop_reads != 0 && rd_cnt == stop_reads) begin
                finished = 1;
            end else if (src_q.size() == 0 && !busy_s) begin
                idle_run++;
                if (idle_run >= 3) finished = 1;
            end else begin
                idle_run = 0;
            end
        end
        n_checks++;
        if (!finished) begin
            n_err++;
            $display("FAIL timeout: stream did not drain in %0d cycles, got %0d words", max_cycles, got_q.size());
        end
    endtask

    task automatic test_reset();
        sel = 0;
        do_reset();
        n_checks++;
        if ({busy4, wr4, rd4, done4} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_dut4: busy,write,read,done=%b expected 0000", {busy4, wr4, rd4, done4});
        end
        n_checks++;
        if ({busy2, wr2, rd2, done2} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_dut2: busy,write,read,done=%b expected 0000", {busy2, wr2, rd2, done2});
        end
    endtask

    task automatic test_single_packet(input int bp_pct, input string tag);
        sel = 0;
        do_reset();
        stim_q = '{32'd1, 32'd2, 32'd3, 32'd4};
        src_q = stim_q;
        build_exp(4, 0);
        drive_stream(300, bp_pct, 0, 1'b0, 0);
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_err++;
            $display("FAIL %s_len: got %0d words expected %0d", tag, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL %s_word%0d: got %h expected %h", tag, i, got_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (rd_cnt !== 4) begin
            n_err++;
            $display("FAIL %s_reads: in_V_read cycles %0d expected 4", tag, rd_cnt);
        end
        n_checks++;
        if (done_cnt !== 1) begin
            n_err++;
            $display("FAIL %s_pkt_done: pulses %0d expected 1", tag, done_cnt);
        end
    endtask

    task automatic test_flush_partial();
        sel = 0;
        do_reset();
        stim_q = '{32'h00010002, 32'hFFFF0003};
        src_q = stim_q;
        build_exp(4, 0);
        drive_stream(300, 0, 0, 1'b1, 0);
        n_checks++;
        if (got_q.size() !== 4) begin
            n_err++;
            $display("FAIL flush_len: got %0d words expected 4", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL flush_word%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (done_cnt !== 1) begin
            n_err++;
            $display("FAIL flush_pkt_done: pulses %0d expected 1", done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        sel = 1;
        do_reset();
        stim_q.delete();
        for (int i = 0; i < 6; i++) stim_q.push_back($urandom());
        src_q = stim_q;
        build_exp(2, 0);
        drive_stream(300, 0, 0, 1'b0, 0);
        n_checks++;
        if (got_q.size() !== 12) begin
            n_err++;
            $display("FAIL b2b_len: got %0d words expected 12", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL b2b_word%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (done_cnt !== 3) begin
            n_err++;
            $display("FAIL b2b_pkt_done: pulses %0d expected 3", done_cnt);
        end
    endtask

    task automatic test_random(input int which, input int nwords, input int plen);
        sel = which;
        do_reset();
        stim_q.delete();
        for (int i = 0; i < nwords; i++) stim_q.push_back($urandom());
        src_q = stim_q;
        build_exp(plen, 0);
        drive_stream(2000, 40, 30, 1'b1, 0);
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_err++;
            $display("FAIL rand%0d_len: got %0d words expected %0d", which, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL rand%0d_word%0d: got %h expected %h", which, i, got_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (done_cnt !== exp_pkts) begin
            n_err++;
            $display("FAIL rand%0d_pkt_done: pulses %0d expected %0d", which, done_cnt, exp_pkts);
        end
    endtask

    task automatic test_reset_mid_packet();
        sel = 0;
        do_reset();
        stim_q = '{32'd1, 32'd2, 32'd3, 32'd4};
        src_q = stim_q;
        drive_stream(100, 0, 0, 1'b0, 2);
        do_reset();
        n_checks++;
        if ({busy4, wr4, done4} !== 3'b000) begin
            n_err++;
            $display("FAIL rst_mid_idle: busy,write,done=%b expected 000", {busy4, wr4, done4});
        end
        stim_q = '{32'd7, 32'd8, 32'd9, 32'd10};
        src_q = stim_q;
        build_exp(4, 0);
        drive_stream(300, 0, 0, 1'b0, 0);
        n_checks++;
        if (got_q.size() !== 6) begin
            n_err++;
            $display("FAIL rst_mid_len: got %0d words expected 6", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL rst_mid_word%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_flush_idle();
        sel = 0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            empty_n_drv = 1'b0;
            full_n_drv = 1'b1;
            flush_drv = 1'b1;
            #1;
            n_checks++;
            if (wr4 !== 1'b0 || busy4 !== 1'b0) begin
                n_err++;
                $display("FAIL flush_idle_c%0d: write=%b busy=%b expected 0 0", c, wr4, busy4);
            end
        end
        flush_drv = 1'b0;
    endtask

    initial begin
        sel = 0;
        ap_rst = 1'b1;
        empty_n_drv = 1'b0;
        full_n_drv = 1'b1;
        flush_drv = 1'b0;
        dout_drv = 32'd0;
        test_reset();
        test_single_packet(0, "single");
        test_flush_partial();
        test_back_to_back();
        test_single_packet(50, "bp");
        test_single_packet(50, "bp2");
        test_random(0, 11, 4);
        test_random(1, 5, 2);
        test_reset_mid_packet();
        test_flush_idle();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/stream_framer.md
Name: stream_framer

Overview:
- Sits directly downstream of the process2→ARM FIFO (fifo3) and drives a second ap_fifo-style FIFO that feeds the /dev/xillybus_read_32 read path.
- Groups the 32-bit result stream into framed packets: a header word, up to PKT_LEN payload words, then a trailer word.
- Lets host software delimit and check results.
- A flush input closes a partial packet when the upstream stream goes idle.

Parameters:
- PKT_LEN, 64, maximum payload words per packet; legal range 1..65535.
- MAGIC, 16'hA5C3, constant placed in header bits [31:16].

Ports:
- ap_clk  input  1  single clock (bus_clk domain).
- ap_rst  input  1  reset, synchronous, active-high.
- in_V_dout  input  32  upstream FIFO data; valid while in_V_empty_n=1.
- in_V_empty_n  input  1  upstream FIFO holds at least one word.
- in_V_read  output  1  pops the upstream FIFO in the same cycle it is high.
- out_V_din  output  32  downstream FIFO write data.
- out_V_full_n  input  1  downstream FIFO can accept a word.
- out_V_write  output  1  writes out_V_din this cycle.
- flush  input  1  level; close the open packet once the input is empty.
- busy  output  1  high in any state other than IDLE.
- pkt_done  output  1  one-cycle pulse, registered, in the cycle after a trailer is written.

Behaviour:
- Reset (ap_rst=1 at a clock edge): state=IDLE, seq=0, cnt=0, csum=0, pkt_done=0.
- Reset outputs: in_V_read=0, out_V_write=0, busy=0.
- Reset mid-packet abandons the packet: no trailer is emitted and seq is not advanced.
- Handshake rules:
  - in_V_read is asserted only when in_V_empty_n=1.
  - out_V_write is asserted only when out_V_full_n=1.
  - No word is dropped or duplicated.
- States:
  - IDLE: outputs idle. When in_V_empty_n=1, go to HDR. No word is consumed in this transition.
  - HDR: out_V_din={MAGIC, seq[15:0]}. out_V_write=out_V_full_n. On write, clear cnt and csum, then go to PAY. Stall while out_V_full_n=0.
  - PAY: combinational pass-through, no added latency.
    - out_V_din=in_V_dout.
    - in_V_read = out_V_write = in_V_empty_n & out_V_full_n.
    - On each transfer: cnt<=cnt+1 and csum<=csum+in_V_dout[31:16]+in_V_dout[15:0] (mod 2^16).
    - If the transfer makes cnt+1==PKT_LEN, go to TRL.
    - Otherwise, if flush=1, in_V_empty_n=0 and cnt>0, go to TRL.
    - Flush with cnt==0 is ignored; an empty packet is never emitted.
  - TRL: out_V_din={cnt[15:0], csum[15:0]}. On write (out_V_full_n=1): seq<=seq+1 (wraps 0xFFFF→0), pkt_done<=1, go to IDLE. Stall while out_V_full_n=0.
- Simultaneous events:
  - Flush during HDR, or flush while in_V_empty_n=1, has no effect. The word is still transferred.
  - When the final (PKT_LEN-th) transfer coincides with flush, the packet closes normally with one trailer.
- Throughput:
  - One payload word per cycle under no backpressure.
  - Per-packet overhead is 3 cycles (IDLE, HDR, TRL) when the input is continuously non-empty.
- The cnt and csum widths are 16 bits. PKT_LEN≤65535 guarantees no overflow of cnt.

Test Plan:
- PKT_LEN=4; input 1,2,3,4 with no backpressure -> output 0xA5C30000, 1, 2, 3, 4, 0x0004000A.
  - in_V_read high for exactly 4 cycles; one pkt_done pulse.
- PKT_LEN=4; input 0x00010002, 0xFFFF0003, then idle with flush=1 -> output 0xA5C30000, 0x00010002, 0xFFFF0003, 0x00020005.
  - csum wraps mod 2^16.
- PKT_LEN=2; 6 input words -> three packets with headers 0xA5C30000, 0xA5C30001, 0xA5C30002; three pkt_done pulses.
- Random out_V_full_n toggling (50%) during HDR, PAY and TRL on the scenario-1 stimulus -> identical output word sequence.
  - Never out_V_write=1 while out_V_full_n=0.
  - Never in_V_read=1 while in_V_empty_n=0.
- ap_rst pulsed after 2 payload words of a PKT_LEN=4 packet, then input 7,8,9,10 -> outputs 0xA5C30000, 7, 8, 9, 10, 0x00040022.
  - busy=0 in the cycle after reset.
- flush=1 held while in IDLE with an empty input -> no output writes, busy stays 0.
